// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and constants for the round-robin register-bank arbiter.
package dff_bank_arbiter_pkg;

  localparam int unsigned NUM_REQ_DEF  = 4;
  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned MAX_HOLD_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned PTR_W_DEF = idx_w(NUM_REQ_DEF);

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import dff_bank_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned PTR_W   = PTR_W_DEF
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_c,
  output logic [PTR_W-1:0]   win_idx_c
);

  logic               found;
  int                 pos;
  logic [NUM_REQ-1:0] sh;

  always_comb begin
    win_c     = '0;
    win_idx_c = '0;
    found     = 1'b0;
    pos       = 0;
    sh        = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      pos = (int'(ptr) + k) % int'(NUM_REQ);
      sh  = req >> pos;
      if (!found && sh[0]) begin
        found     = 1'b1;
        win_c     = NUM_REQ'(1) << pos;
        win_idx_c = PTR_W'(pos);
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sequencing NUM_REQ requesters into one shared DATA_W register,
// with a per-grant capture limit so a busy requester cannot starve the others.
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   din,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]           q,
  output logic                        q_vld,
  output logic                        busy
);

  localparam int unsigned PTR_W  = idx_w(NUM_REQ);
  localparam int unsigned HOLD_W = idx_w(MAX_HOLD + 1);

  state_e              state;
  logic [PTR_W-1:0]    gidx;
  logic [PTR_W-1:0]    ptr;
  logic [HOLD_W-1:0]   hold_cnt;

  logic [PTR_W-1:0]    nxt_c;
  logic [PTR_W-1:0]    pick_ptr_c;
  logic [NUM_REQ-1:0]  win_c;
  logic [PTR_W-1:0]    win_idx_c;
  logic                req_g_c;
  logic                release_c;

  // On release the pointer moves past the current holder, and re-arbitration in
  // the same edge must already see that moved pointer.
  always_comb begin
    nxt_c      = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    pick_ptr_c = (state == ST_GRANT) ? nxt_c : ptr;
    req_g_c    = req[gidx];
    release_c  = !req_g_c || ((hold_cnt + 1'b1) == HOLD_W'(MAX_HOLD));
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req       (req),
    .ptr       (pick_ptr_c),
    .win_c     (win_c),
    .win_idx_c (win_idx_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      gidx     <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      q        <= '0;
      q_vld    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          q_vld <= 1'b0;
          if (|req) begin
            gnt      <= win_c;
            gidx     <= win_idx_c;
            hold_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (req_g_c) begin
            q        <= din[32'(gidx)*DATA_W +: DATA_W];
            q_vld    <= 1'b1;
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            q_vld <= 1'b0;
          end
          if (release_c) begin
            ptr      <= nxt_c;
            hold_cnt <= '0;
            if (|req) begin
              gnt  <= win_c;
              gidx <= win_idx_c;
            end else begin
              gnt   <= '0;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
